// File: rtl/scroll_latch_bank_pkg.sv
// Shared register offsets and the registered CPU bus payload for the CUS47 latch responder.
package scroll_latch_bank_pkg;

    localparam logic [1:0] OFS_XHI_PRI = 2'd0;
    localparam logic [1:0] OFS_XLO     = 2'd1;
    localparam logic [1:0] OFS_Y       = 2'd2;
    localparam logic [1:0] OFS_BANK    = 2'd3;

    typedef struct packed {
        logic       nwe;
        logic [2:0] a;
        logic [7:0] d;
    } lth_bus_t;

    // A[2] picks the tile layer; A[1:0] is the offset within it.
    function automatic logic layer_sel(input logic [2:0] a);
        return a[2];
    endfunction

endpackage

// File: rtl/scroll_layer_regs.sv
// Shadow and (optionally) active scroll/priority registers for one tile layer.
module scroll_layer_regs
    import scroll_latch_bank_pkg::*;
#(
    parameter bit          BUFFERED      = 1'b1,
    parameter int unsigned XSCROLL_WIDTH = 9,
    parameter int unsigned PRI_WIDTH     = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [1:0]               ofs_i,
    input  logic [7:0]               d_i,
    input  logic                     xfer_i,
    output logic [XSCROLL_WIDTH-1:0] x_o,
    output logic [7:0]               y_o,
    output logic [PRI_WIDTH-1:0]     pri_o,
    output logic                     dirty_o
);

    localparam int unsigned XHI_W = XSCROLL_WIDTH - 8;

    logic [XSCROLL_WIDTH-1:0] sh_x_q, sh_x_d;
    logic [7:0]               sh_y_q, sh_y_d;
    logic [PRI_WIDTH-1:0]     sh_pri_q, sh_pri_d;
    logic                     dirty_q, dirty_d;

    always_comb begin
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_pri_d = sh_pri_q;
        dirty_d  = dirty_q;
        if (wr_en_i) begin
            case (ofs_i)
                OFS_XHI_PRI: begin
                    sh_x_d[XSCROLL_WIDTH-1:8] = d_i[XHI_W-1:0];
                    sh_pri_d                  = d_i[7 -: PRI_WIDTH];
                end
                OFS_XLO: sh_x_d[7:0] = d_i;
                OFS_Y:   sh_y_d      = d_i;
                default: ;
            endcase
        end
        // A write in the same cycle as a transfer stays pending for the next VBLANK.
        if (!BUFFERED)    dirty_d = 1'b0;
        else if (wr_en_i) dirty_d = 1'b1;
        else if (xfer_i)  dirty_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_x_q   <= '0;
            sh_y_q   <= '0;
            sh_pri_q <= '0;
            dirty_q  <= 1'b0;
        end else begin
            sh_x_q   <= sh_x_d;
            sh_y_q   <= sh_y_d;
            sh_pri_q <= sh_pri_d;
            dirty_q  <= dirty_d;
        end
    end

    assign dirty_o = dirty_q;

    if (BUFFERED) begin : g_buf
        logic [XSCROLL_WIDTH-1:0] act_x_q;
        logic [7:0]               act_y_q;
        logic [PRI_WIDTH-1:0]     act_pri_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                act_x_q   <= '0;
                act_y_q   <= '0;
                act_pri_q <= '0;
            end else if (xfer_i) begin
                act_x_q   <= sh_x_q;
                act_y_q   <= sh_y_q;
                act_pri_q <= sh_pri_q;
            end
        end

        assign x_o   = act_x_q;
        assign y_o   = act_y_q;
        assign pri_o = act_pri_q;
    end else begin : g_unbuf
        assign x_o   = sh_x_q;
        assign y_o   = sh_y_q;
        assign pri_o = sh_pri_q;
    end

endmodule

// File: rtl/scroll_latch_bank.sv
// CUS47 latch-strobe responder: samples sub-CPU writes into two layer register sets and a ROM bank.
module scroll_latch_bank
    import scroll_latch_bank_pkg::*;
#(
    parameter bit          BUFFERED      = 1'b1,
    parameter int unsigned XSCROLL_WIDTH = 9,
    parameter int unsigned PRI_WIDTH     = 3,
    parameter int unsigned BANK_WIDTH    = 2
) (
    input  logic                     CLK_6M,
    input  logic                     nRST,
    input  logic                     nLTH,
    input  logic                     nWE,
    input  logic [2:0]               A,
    input  logic [7:0]               D,
    input  logic                     nVBLK,
    output logic [XSCROLL_WIDTH-1:0] XSCR0,
    output logic [7:0]               YSCR0,
    output logic [PRI_WIDTH-1:0]     PRI0,
    output logic [XSCROLL_WIDTH-1:0] XSCR1,
    output logic [7:0]               YSCR1,
    output logic [PRI_WIDTH-1:0]     PRI1,
    output logic [BANK_WIDTH-1:0]    BANK,
    output logic                     PENDING
);

    lth_bus_t              bus_q;
    logic                  nlth_q, nlth_qq;
    logic                  nvblk_q, nvblk_qq;
    logic                  arm_q;
    logic [BANK_WIDTH-1:0] bank_q, bank_d;
    logic                  wr_ev_c, xfer_c, wr_l0_c, wr_l1_c, wr_bank_c;
    logic                  dirty0, dirty1;

    // Input stage keeps sampling through reset so a strobe held low across release looks stale.
    always_ff @(posedge CLK_6M) begin
        bus_q   <= '{nwe: nWE, a: A, d: D};
        nlth_q  <= nLTH;
        nvblk_q <= nVBLK;
    end

    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            nlth_qq  <= 1'b1;
            nvblk_qq <= 1'b1;
            arm_q    <= 1'b0;
            bank_q   <= '0;
        end else begin
            nlth_qq  <= nlth_q;
            nvblk_qq <= nvblk_q;
            arm_q    <= 1'b1;
            bank_q   <= bank_d;
        end
    end

    always_comb begin
        wr_ev_c   = arm_q & ~nlth_q & nlth_qq & ~bus_q.nwe;
        xfer_c    = arm_q & ~nvblk_q & nvblk_qq;
        wr_l0_c   = wr_ev_c & ~layer_sel(bus_q.a) & (bus_q.a[1:0] != OFS_BANK);
        wr_l1_c   = wr_ev_c &  layer_sel(bus_q.a) & (bus_q.a[1:0] != OFS_BANK);
        wr_bank_c = wr_ev_c & (bus_q.a == {1'b0, OFS_BANK});
        bank_d    = bank_q;
        if (wr_bank_c) bank_d = bus_q.d[BANK_WIDTH-1:0];
    end

    scroll_layer_regs #(
        .BUFFERED      (BUFFERED),
        .XSCROLL_WIDTH (XSCROLL_WIDTH),
        .PRI_WIDTH     (PRI_WIDTH)
    ) u_layer0 (
        .clk_i   (CLK_6M),
        .rst_ni  (nRST),
        .wr_en_i (wr_l0_c),
        .ofs_i   (bus_q.a[1:0]),
        .d_i     (bus_q.d),
        .xfer_i  (xfer_c),
        .x_o     (XSCR0),
        .y_o     (YSCR0),
        .pri_o   (PRI0),
        .dirty_o (dirty0)
    );

    scroll_layer_regs #(
        .BUFFERED      (BUFFERED),
        .XSCROLL_WIDTH (XSCROLL_WIDTH),
        .PRI_WIDTH     (PRI_WIDTH)
    ) u_layer1 (
        .clk_i   (CLK_6M),
        .rst_ni  (nRST),
        .wr_en_i (wr_l1_c),
        .ofs_i   (bus_q.a[1:0]),
        .d_i     (bus_q.d),
        .xfer_i  (xfer_c),
        .x_o     (XSCR1),
        .y_o     (YSCR1),
        .pri_o   (PRI1),
        .dirty_o (dirty1)
    );

    assign BANK    = bank_q;
    assign PENDING = dirty0 | dirty1;

endmodule

// File: tb/tb_scroll_latch_bank.sv
// Directed bench for scroll_latch_bank: unbuffered and buffered instances share one CPU bus.
module tb_scroll_latch_bank;

    logic       clk = 1'b0;
    logic       nRST, nLTH, nWE, nVBLK;
    logic [2:0] A;
    logic [7:0] D;

    logic [8:0] u_x0, u_x1, b_x0, b_x1;
    logic [7:0] u_y0, u_y1, b_y0, b_y1;
    logic [2:0] u_p0, u_p1, b_p0, b_p1;
    logic [1:0] u_bank, b_bank;
    logic       u_pend, b_pend;

    always #5 clk = ~clk;

    scroll_latch_bank #(.BUFFERED(1'b0)) u_unbuf (
        .CLK_6M(clk), .nRST(nRST), .nLTH(nLTH), .nWE(nWE), .A(A), .D(D), .nVBLK(nVBLK),
        .XSCR0(u_x0), .YSCR0(u_y0), .PRI0(u_p0), .XSCR1(u_x1), .YSCR1(u_y1), .PRI1(u_p1),
        .BANK(u_bank), .PENDING(u_pend)
    );

    scroll_latch_bank #(.BUFFERED(1'b1)) u_buf (
        .CLK_6M(clk), .nRST(nRST), .nLTH(nLTH), .nWE(nWE), .A(A), .D(D), .nVBLK(nVBLK),
        .XSCR0(b_x0), .YSCR0(b_y0), .PRI0(b_p0), .XSCR1(b_x1), .YSCR1(b_y1), .PRI1(b_p1),
        .BANK(b_bank), .PENDING(b_pend)
    );

    // Reference model: shadow registers, buffered active copy, bank and pending flag.
    logic [8:0] m_shx [2];
    logic [8:0] m_acx [2];
    logic [7:0] m_shy [2];
    logic [7:0] m_acy [2];
    logic [2:0] m_shp [2];
    logic [2:0] m_acp [2];
    logic [1:0] m_bank;
    logic       m_pend;

    typedef struct {
        string       tag;
        int          id;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    string names [16] = '{"u.XSCR0", "u.YSCR0", "u.PRI0", "u.XSCR1", "u.YSCR1", "u.PRI1",
                          "u.BANK", "u.PENDING", "b.XSCR0", "b.YSCR0", "b.PRI0", "b.XSCR1",
                          "b.YSCR1", "b.PRI1", "b.BANK", "b.PENDING"};

    function automatic logic [15:0] obs(input int id);
        case (id)
            0:  return 16'(u_x0);
            1:  return 16'(u_y0);
            2:  return 16'(u_p0);
            3:  return 16'(u_x1);
            4:  return 16'(u_y1);
            5:  return 16'(u_p1);
            6:  return 16'(u_bank);
            7:  return 16'(u_pend);
            8:  return 16'(b_x0);
            9:  return 16'(b_y0);
            10: return 16'(b_p0);
            11: return 16'(b_x1);
            12: return 16'(b_y1);
            13: return 16'(b_p1);
            14: return 16'(b_bank);
            default: return 16'(b_pend);
        endcase
    endfunction

    function automatic logic [15:0] model_val(input int id);
        case (id)
            0:  return 16'(m_shx[0]);
            1:  return 16'(m_shy[0]);
            2:  return 16'(m_shp[0]);
            3:  return 16'(m_shx[1]);
            4:  return 16'(m_shy[1]);
            5:  return 16'(m_shp[1]);
            6:  return 16'(m_bank);
            7:  return 16'h0000;
            8:  return 16'(m_acx[0]);
            9:  return 16'(m_acy[0]);
            10: return 16'(m_acp[0]);
            11: return 16'(m_acx[1]);
            12: return 16'(m_acy[1]);
            13: return 16'(m_acp[1]);
            14: return 16'(m_bank);
            default: return 16'(m_pend);
        endcase
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_shx[l] = '0; m_acx[l] = '0;
            m_shy[l] = '0; m_acy[l] = '0;
            m_shp[l] = '0; m_acp[l] = '0;
        end
        m_bank = '0;
        m_pend = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        int l;
        l = a[2] ? 1 : 0;
        case (a[1:0])
            2'd0: begin m_shx[l][8] = d[0]; m_shp[l] = d[7:5]; end
            2'd1: m_shx[l][7:0] = d;
            2'd2: m_shy[l] = d;
            default: ;
        endcase
        if (a == 3'd3) m_bank = d[1:0];
        if (a[1:0] != 2'd3) m_pend = 1'b1;
    endtask

    task automatic model_xfer();
        for (int l = 0; l < 2; l++) begin
            m_acx[l] = m_shx[l];
            m_acy[l] = m_shy[l];
            m_acp[l] = m_shp[l];
        end
        m_pend = 1'b0;
    endtask

    task automatic push_exp(input string tag);
        for (int i = 0; i < 16; i++) sb.push_back('{tag, i, model_val(i)});
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [15:0] o;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $error("FAIL sb_empty: observed no entry, expected an entry");
            end else begin
                e = sb.pop_front();
                o = obs(e.id);
                assert (o === e.val) else begin
                    n_bad++;
                    $error("FAIL %s.%s: observed %0h expected %0h", e.tag, names[e.id], o, e.val);
                end
            end
        end
    endtask

    // One strobe; hold counts extra low cycles, during which D is scrambled.
    task automatic strobe(input logic [2:0] a, input logic [7:0] d, input logic we_n,
                          input int hold, input string tag);
        @(negedge clk);
        nLTH = 1'b0; A = a; D = d; nWE = we_n;
        push_exp({tag, "_pre"});
        if (!we_n && a != 3'd7) model_write(a, d);
        push_exp(tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) pop_check();
            D = 8'($urandom);
        end
        nLTH = 1'b1;
        @(negedge clk);
        pop_check();
    endtask

    task automatic vblank(input string tag);
        @(negedge clk);
        nVBLK = 1'b0;
        push_exp({tag, "_pre"});
        model_xfer();
        push_exp(tag);
        @(negedge clk);
        pop_check();
        nVBLK = 1'b1;
        @(negedge clk);
        pop_check();
    endtask

    task automatic collide(input logic [2:0] a, input logic [7:0] d, input string tag);
        @(negedge clk);
        nLTH = 1'b0; A = a; D = d; nWE = 1'b0; nVBLK = 1'b0;
        push_exp({tag, "_pre"});
        model_xfer();
        model_write(a, d);
        push_exp(tag);
        @(negedge clk);
        pop_check();
        nLTH = 1'b1; nVBLK = 1'b1;
        @(negedge clk);
        pop_check();
    endtask

    initial begin
        nRST = 1'b0; nLTH = 1'b0; nWE = 1'b0; A = 3'd0; D = 8'hFF; nVBLK = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        push_exp("reset");
        pop_check();
        nRST = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("reset_release");
        pop_check();
        nLTH = 1'b1;
        @(negedge clk);

        strobe(3'd0, 8'hA1, 1'b0, 1, "w0_xhi");
        strobe(3'd1, 8'h34, 1'b0, 1, "w1_xlo");
        strobe(3'd2, 8'h56, 1'b0, 1, "w2_y");
        vblank("vbl1");

        strobe(3'd5, 8'h80, 1'b0, 1, "w5_xlo1");
        vblank("vbl2");

        strobe(3'd3, 8'hFE, 1'b0, 1, "w3_bank");

        collide(3'd2, 8'h11, "collide");
        vblank("vbl3");

        strobe(3'd4, 8'h3F, 1'b0, 20, "held20");
        strobe(3'd7, 8'hAA, 1'b0, 1, "ofs7");
        strobe(3'd1, 8'h55, 1'b1, 1, "nwe_high");
        vblank("vbl4");

        @(negedge clk);
        nLTH = 1'b0; A = 3'd1; D = 8'hFF; nWE = 1'b0;
        @(negedge clk);
        nRST = 1'b0;
        @(negedge clk);
        model_reset();
        push_exp("reset_mid");
        pop_check();
        nRST = 1'b1; nLTH = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
